// File: rtl/registro_condiciones_pkg.sv
// ============================================================================
// Module   : registro_condiciones_pkg
// Brief    : Shared condition codes, FSM encoding and flag bit positions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package registro_condiciones_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EVAL = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/evaluador_cond.sv
// ============================================================================
// Module   : evaluador_cond
// Brief    : Combinational condition-code evaluator against an {N,Z,C,V} word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module evaluador_cond
  import registro_condiciones_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       taken
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond_code)
      COND_EQ: taken = w_z;
      COND_NE: taken = ~w_z;
      COND_CS: taken = w_c;
      COND_CC: taken = ~w_c;
      COND_MI: taken = w_n;
      COND_PL: taken = ~w_n;
      COND_VS: taken = w_v;
      COND_VC: taken = ~w_v;
      COND_HI: taken = w_c & ~w_z;
      COND_LS: taken = ~w_c | w_z;
      COND_GE: taken = (w_n == w_v);
      COND_LT: taken = (w_n != w_v);
      COND_GT: taken = ~w_z & (w_n == w_v);
      COND_LE: taken = w_z | (w_n != w_v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/registro_condiciones.sv
// ============================================================================
// Module   : registro_condiciones
// Brief    : Flag register, condition query FSM, sticky V and overflow counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module registro_condiciones
  import registro_condiciones_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             negative,
  input  logic             zero,
  input  logic             carry,
  input  logic             overflow,
  input  logic             upd,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             res_valid,
  output logic             res_taken,
  input  logic             res_ready,
  input  logic             clr_sticky,
  output logic [3:0]       flags_q,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next_state;
  logic [3:0]      r_code;
  logic            w_taken;
  logic            w_accept;
  logic            w_ovf_upd;

  assign w_accept  = (r_state == ST_IDLE) && cond_valid;
  assign w_ovf_upd = upd && overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (upd) begin
      flags_q <= {negative, zero, carry, overflow};
    end
  end

  // Evaluation reads flags_q during EVAL, so an update at the accept edge is seen.
  evaluador_cond u_evaluador (
    .cond_code (r_code),
    .flags     (flags_q),
    .taken     (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (cond_valid) w_next_state = ST_EVAL;
      ST_EVAL: w_next_state = ST_RESP;
      ST_RESP: if (res_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cond_ready = (r_state == ST_IDLE);
    res_valid  = (r_state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= 4'h0;
      res_taken <= 1'b0;
    end else begin
      if (w_accept) begin
        r_code <= cond_code;
      end
      if (r_state == ST_EVAL) begin
        res_taken <= w_taken;
      end
    end
  end

  // A qualifying overflow update takes priority over a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else if (w_ovf_upd) begin
      sticky_v <= 1'b1;
      if (clr_sticky) begin
        ovf_count <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end else if (clr_sticky) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_registro_condiciones.sv
// ============================================================================
// Module   : tb_registro_condiciones
// Brief    : Directed self-checking bench for registro_condiciones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_registro_condiciones;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             negative = 1'b0, zero = 1'b0, carry = 1'b0, overflow = 1'b0;
  logic             upd = 1'b0;
  logic             cond_valid = 1'b0;
  logic [3:0]       cond_code = 4'h0;
  logic             cond_ready;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready = 1'b0;
  logic             clr_sticky = 1'b0;
  logic [3:0]       flags_q;
  logic             sticky_v;
  logic [CNT_W-1:0] ovf_count;

  int errors = 0;
  int checks = 0;

  registro_condiciones #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .negative   (negative),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .upd        (upd),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_ready (cond_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_ready  (res_ready),
    .clr_sticky (clr_sticky),
    .flags_q    (flags_q),
    .sticky_v   (sticky_v),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference condition table, written from N/Z/C/V names.
  function automatic logic model(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [3:0] f);
    {negative, zero, carry, overflow} = f;
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  // Runs one query from IDLE and releases it; got=0 if no result appeared.
  task automatic do_query(input logic [3:0] code, output logic taken, output logic got);
    got = 1'b0;
    taken = 1'b0;
    cond_valid = 1'b1;
    cond_code  = code;
    tick();
    cond_valid = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (res_valid) begin
        got = 1'b1;
        taken = res_taken;
      end else begin
        tick();
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({flags_q, sticky_v, ovf_count, res_valid, res_taken, cond_ready} !==
        {4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: flags=%h sticky=%b cnt=%0d rv=%b rt=%b rdy=%b, required 0 0 0 0 0 1",
               flags_q, sticky_v, ovf_count, res_valid, res_taken, cond_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cond_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b rv=%b, required 1 0", cond_ready, res_valid);
    end
  endtask

  task automatic test_basic();
    logic t, g;
    set_flags(4'b0100);
    checks++;
    if (flags_q !== 4'b0100) begin
      errors++;
      $display("FAIL flag_latch: got %b required 0100", flags_q);
    end
    // EQ with explicit latency checks
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    tick();
    cond_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b0) begin
      errors++;
      $display("FAIL eval_cycle: rv=%b rdy=%b, required 0 0", res_valid, cond_ready);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++;
      $display("FAIL eq_latency: rv=%b rt=%b, required 1 1", res_valid, res_taken);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: rv=%b rdy=%b, required 0 1", res_valid, cond_ready);
    end
    do_query(4'h1, t, g);
    checks++;
    if (g !== 1'b1 || t !== 1'b0) begin
      errors++;
      $display("FAIL ne_query: got=%b taken=%b, required 1 0", g, t);
    end
  endtask

  task automatic test_conditions();
    logic [3:0] codes [10] = '{4'hA, 4'hB, 4'hD, 4'hC, 4'h8, 4'h9, 4'hE, 4'hF, 4'hE, 4'hF};
    logic [3:0] flg   [10] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010,
                               4'b0000, 4'b0000, 4'b1111, 4'b1111};
    logic       exp   [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic t, g;
    for (int i = 0; i < 10; i++) begin
      set_flags(flg[i]);
      do_query(codes[i], t, g);
      checks++;
      if (g !== 1'b1 || t !== exp[i]) begin
        errors++;
        $display("FAIL cond_%0d: code=%h flags=%b got=%b taken=%b, required taken=%b",
                 i, codes[i], flg[i], g, t, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic seen;
    set_flags(4'b0100);
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    tick();
    tick();
    // Now in RESP; source holds a new EQ query while flags lose Z
    cond_code = 4'h0;
    {negative, zero, carry, overflow} = 4'b0000;
    upd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_taken !== 1'b1 || cond_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: rv=%b rt=%b rdy=%b, required 1 1 0", i, res_valid, res_taken, cond_ready);
      end
      tick();
      upd = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_accept_on_release: rv=%b rdy=%b, required 0 1", res_valid, cond_ready);
    end
    tick();
    cond_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (res_valid) seen = 1'b1;
      else tick();
    end
    checks++;
    if (seen !== 1'b1 || res_taken !== 1'b0) begin
      errors++;
      $display("FAIL second_query: seen=%b rt=%b, required 1 0", seen, res_taken);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    // upd at the acceptance edge is seen
    set_flags(4'b0000);
    {negative, zero, carry, overflow} = 4'b0100;
    upd = 1'b1;
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    tick();
    upd = 1'b0;
    cond_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++;
      $display("FAIL upd_at_accept: rv=%b rt=%b, required 1 1", res_valid, res_taken);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    // upd at the end of EVAL is not seen
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    tick();
    cond_valid = 1'b0;
    {negative, zero, carry, overflow} = 4'b0000;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1 || flags_q !== 4'b0000) begin
      errors++;
      $display("FAIL upd_end_eval: rv=%b rt=%b flags=%b, required 1 1 0000", res_valid, res_taken, flags_q);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_overflow();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    {negative, zero, carry, overflow} = 4'b0001;
    upd = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    upd = 1'b0;
    checks++;
    if (ovf_count !== 8'd5 || sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count5: cnt=%0d sticky=%b, required 5 1", ovf_count, sticky_v);
    end
    set_flags(4'b0000);
    checks++;
    if (ovf_count !== 8'd5 || sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL no_ovf_upd: cnt=%0d sticky=%b, required 5 1", ovf_count, sticky_v);
    end
    {negative, zero, carry, overflow} = 4'b0001;
    upd = 1'b1;
    for (int i = 0; i < 295; i++) tick();
    upd = 1'b0;
    checks++;
    if (ovf_count !== 8'd255 || sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL ovf_saturate: cnt=%0d sticky=%b, required 255 1", ovf_count, sticky_v);
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (ovf_count !== 8'd0 || sticky_v !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: cnt=%0d sticky=%b, required 0 0", ovf_count, sticky_v);
    end
    set_flags(4'b0001);
    set_flags(4'b0001);
    set_flags(4'b0001);
    clr_sticky = 1'b1;
    set_flags(4'b0001);
    clr_sticky = 1'b0;
    checks++;
    if (ovf_count !== 8'd1 || sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_upd: cnt=%0d sticky=%b, required 1 1", ovf_count, sticky_v);
    end
  endtask

  task automatic test_reset_mid();
    set_flags(4'b1111);
    cond_valid = 1'b1;
    cond_code  = 4'hE;
    tick();
    cond_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || flags_q !== 4'b0000 || sticky_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rv=%b flags=%b sticky=%b, required 0 0000 0", res_valid, flags_q, sticky_v);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0 || cond_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_%0d: rv=%b rdy=%b, required 0 1", i, res_valid, cond_ready);
      end
    end
  endtask

  task automatic test_random();
    logic hit_t [16];
    logic hit_n [16];
    logic [3:0] f, code;
    logic t, g, e;
    for (int i = 0; i < 16; i++) begin
      hit_t[i] = 1'b0;
      hit_n[i] = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      f    = 4'($urandom_range(15, 0));
      code = 4'(i % 16);
      set_flags(f);
      do_query(code, t, g);
      e = model(code, f);
      checks++;
      if (g !== 1'b1 || t !== e) begin
        errors++;
        $display("FAIL rand_%0d: code=%h flags=%b got=%b taken=%b, required %b", i, code, f, g, t, e);
      end
      if (g && t) hit_t[code] = 1'b1;
      if (g && !t) hit_n[code] = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (hit_t[i] !== (i != 15) || hit_n[i] !== (i != 14)) begin
        errors++;
        $display("FAIL coverage_%0d: taken_hit=%b not_hit=%b, required %b %b",
                 i, hit_t[i], hit_n[i], (i != 15), (i != 14));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conditions();
    test_back_to_back();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/registro_condiciones.md
# registro_condiciones

Flag register and condition-code evaluator that sits downstream of the ALU flag generator. It latches the N/Z/C/V flags on an update strobe and answers 4-bit condition-code queries over a valid/ready handshake with a registered taken/not-taken result. It also keeps a sticky overflow bit and a saturating overflow-event counter for debug and readout.

## Interface
Parameters:
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- negative, zero, carry, overflow  input  1 each  flags from the ALU flag generator.
- upd  input  1  latch the four flag inputs at this edge.
- cond_valid  input  1  query present.
- cond_code  input  4  condition to evaluate.
- cond_ready  output  1  block can accept a query.
- res_valid  output  1  result available.
- res_taken  output  1  condition result; meaningful only while res_valid=1.
- res_ready  input  1  consumer takes the result.
- clr_sticky  input  1  clear sticky V and counter.
- flags_q  output  4  registered {N,Z,C,V}.
- sticky_v  output  1  set by any latched overflow since the last clear.
- ovf_count  output  CNT_W  number of latched overflows, saturating.

## Operation
- Flag register: on an edge with upd=1, flags_q <= {negative, zero, carry, overflow}. Otherwise it holds. The carry flag is stored as delivered; it is not inverted for subtraction.
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- FSM states: IDLE, EVAL, RESP.
  - IDLE: cond_ready=1. When cond_valid=1 at an edge, the query is accepted, cond_code is captured, and the FSM moves to EVAL.
  - EVAL: lasts one cycle. The captured code is evaluated against flags_q as it stands in this cycle. At the closing edge, res_taken is registered and the FSM moves to RESP.
  - RESP: res_valid=1 and res_taken is held stable. When res_ready=1 at an edge, the FSM returns to IDLE.
- cond_ready=0 in EVAL and RESP. A query presented there is not accepted and must be held by the source.
- Sticky/counter, on an edge where upd=1 and overflow=1:
  - sticky_v <= 1.
  - ovf_count increments, saturating at 2^CNT_W-1.
- clr_sticky=1 with no qualifying update: sticky_v <= 0 and ovf_count <= 0.
- clr_sticky coinciding with a qualifying update: the update wins over the clear, so sticky_v=1 and ovf_count=1.
- An update with overflow=0 does not touch sticky_v or ovf_count.

## Timing
- Reset values: flags_q=0, sticky_v=0, ovf_count=0, FSM=IDLE, res_valid=0, res_taken=0. cond_ready=1, because it is decoded from IDLE; no acceptance occurs while rst_n=0.
- Reset asserted mid-query aborts the query immediately. After release the block is in IDLE and the query is lost.
- Latency: query accepted at edge k; res_valid rises after edge k+1; minimum turnaround is 3 edges per query.
- Simultaneous events:
  - upd at the acceptance edge k: the evaluation sees the new flags.
  - upd at edge k+1 (the end of EVAL): not seen by this query.
  - upd during RESP: does not alter the held res_taken.
- The block never accepts a new query in the same cycle that it releases a result.
- All outputs are registered, or decoded from FSM state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - condition-code localparams (COND_EQ..COND_NV, 4 bits);
  - FSM state encoding (2 bits: IDLE=0, EVAL=1, RESP=2);
  - flag bit positions within flags_q (N=3, Z=2, C=1, V=0).
- Sub-module evaluador_cond is purely combinational: (cond_code[3:0], flags[3:0]) -> taken. It is reusable by future branch logic.
- The top level holds the flag register, the FSM, the sticky bit and the counter.

## Test plan
- Reset, then upd with N=0,Z=1,C=0,V=0; query EQ. Required: res_valid 2 edges after acceptance, res_taken=1. Query NE: res_taken=0.
- Flags N=1,V=0: GE->0, LT->1, LE->1, GT->0. Flags C=1,Z=0: HI->1, LS->0. AL->1 and NV->0 for any flags.
- Hold res_ready=0 for 5 cycles in RESP, with upd changing flags and a new cond_valid asserted. Required: res_taken stable, cond_ready=0, second query accepted only after release.
- 300 updates with overflow=1 at CNT_W=8. Required: ovf_count saturates at 255 and sticky_v=1. clr_sticky alone gives 0/0. clr_sticky with a concurrent overflow update gives sticky_v=1, ovf_count=1.
- Assert rst_n=0 during EVAL. Required: res_valid=0 and flags_q=0 immediately; after release cond_ready=1 and no spurious res_valid.
- Randomized flags and codes checked against a reference model of the condition table. Required: all 16 codes hit with both outcomes where reachable.
